// File: rtl/ex_pipeline_hazard_controller.sv
// Stall/flush/hold sequencer for the 5-stage core: load-use bubbles, mult/div EX occupancy, branch flush, HALT drain, debug step.
// Latency: outputs are combinational (Mealy) from registered state/counter and current inputs; state updates on the next edge.
// Backpressure: a low global enable (step mode without a step pulse) freezes state and counter and deasserts every control.
module ex_pipeline_hazard_controller #(
    parameter int RNBITS       = 5,
    parameter int MD_LATENCY   = 4,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNTBITS      = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ID_EX_MemRead,
    input  logic [RNBITS-1:0] i_ID_EX_Rt,
    input  logic [RNBITS-1:0] i_IF_ID_Rs,
    input  logic [RNBITS-1:0] i_IF_ID_Rt,
    input  logic              i_branch_taken,
    input  logic              i_md_start,
    input  logic              i_halt,
    input  logic              i_debug_mode,
    input  logic              i_step,
    output logic              o_pc_write,
    output logic              o_IF_ID_write,
    output logic              o_IF_ID_flush,
    output logic              o_ID_EX_write,
    output logic              o_ID_EX_flush,
    output logic              o_EX_MEM_flush,
    output logic              o_pipe_en,
    output logic              o_halted,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MD_WAIT = 2'b01,
        ST_DRAIN   = 2'b10,
        ST_HALTED  = 2'b11
    } state_e;

    localparam logic [CNTBITS-1:0] MD_LOAD    = CNTBITS'(MD_LATENCY - 1);
    localparam logic [CNTBITS-1:0] DRAIN_LOAD = CNTBITS'(DRAIN_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNTBITS-1:0] cnt_q, cnt_d;
    logic               en;
    logic               load_use;

    assign en = !i_debug_mode || i_step;

    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = i_ID_EX_MemRead && (i_ID_EX_Rt != '0) &&
                      ((i_ID_EX_Rt == i_IF_ID_Rs) || (i_ID_EX_Rt == i_IF_ID_Rt));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        o_pc_write     = 1'b0;
        o_IF_ID_write  = 1'b0;
        o_IF_ID_flush  = 1'b0;
        o_ID_EX_write  = 1'b0;
        o_ID_EX_flush  = 1'b0;
        o_EX_MEM_flush = 1'b0;
        o_pipe_en      = 1'b0;

        if (en) begin
            unique case (state_q)
                ST_RUN: begin
                    o_pc_write    = 1'b1;
                    o_IF_ID_write = 1'b1;
                    o_ID_EX_write = 1'b1;
                    o_pipe_en     = 1'b1;
                    if (i_halt) begin
                        o_pc_write    = 1'b0;
                        o_IF_ID_flush = 1'b1;
                        state_d       = ST_DRAIN;
                        cnt_d         = DRAIN_LOAD;
                    end else if (i_md_start) begin
                        state_d = ST_MD_WAIT;
                        cnt_d   = MD_LOAD;
                    end else if (load_use) begin
                        // Branch in ID is deliberately ignored: it re-resolves once the load data is forwardable.
                        o_pc_write    = 1'b0;
                        o_IF_ID_write = 1'b0;
                        o_ID_EX_flush = 1'b1;
                    end else if (i_branch_taken) begin
                        o_IF_ID_flush = 1'b1;
                    end
                end
                ST_MD_WAIT: begin
                    o_EX_MEM_flush = 1'b1;
                    o_pipe_en      = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    o_IF_ID_write = 1'b1;
                    o_IF_ID_flush = 1'b1;
                    o_ID_EX_write = 1'b1;
                    o_pipe_en     = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_HALTED;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign o_halted = (state_q == ST_HALTED);
    assign o_state  = state_q;

endmodule

// File: tb/tb_ex_pipeline_hazard_controller.sv
// Directed-vector bench for ex_pipeline_hazard_controller with hand-computed control vectors.
module tb_ex_pipeline_hazard_controller;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_ID_EX_MemRead = 1'b0;
    logic [4:0] i_ID_EX_Rt = '0;
    logic [4:0] i_IF_ID_Rs = '0;
    logic [4:0] i_IF_ID_Rt = '0;
    logic       i_branch_taken = 1'b0;
    logic       i_md_start = 1'b0;
    logic       i_halt = 1'b0;
    logic       i_debug_mode = 1'b0;
    logic       i_step = 1'b0;
    logic       o_pc_write, o_IF_ID_write, o_IF_ID_flush, o_ID_EX_write;
    logic       o_ID_EX_flush, o_EX_MEM_flush, o_pipe_en, o_halted;
    logic [1:0] o_state;

    int n_checks = 0;
    int n_errors = 0;

    // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_flush, pipe_en}
    localparam logic [6:0] V_NORM  = 7'b1101001;
    localparam logic [6:0] V_LU    = 7'b0001101;
    localparam logic [6:0] V_BR    = 7'b1111001;
    localparam logic [6:0] V_HALT  = 7'b0111001;
    localparam logic [6:0] V_MDW   = 7'b0000011;
    localparam logic [6:0] V_DRAIN = 7'b0111001;
    localparam logic [6:0] V_OFF   = 7'b0000000;

    logic [6:0] ctl;
    assign ctl = {o_pc_write, o_IF_ID_write, o_IF_ID_flush, o_ID_EX_write,
                  o_ID_EX_flush, o_EX_MEM_flush, o_pipe_en};

    ex_pipeline_hazard_controller #(
        .RNBITS(5), .MD_LATENCY(4), .DRAIN_CYCLES(4), .CNTBITS(3)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_ID_EX_MemRead(i_ID_EX_MemRead), .i_ID_EX_Rt(i_ID_EX_Rt),
        .i_IF_ID_Rs(i_IF_ID_Rs), .i_IF_ID_Rt(i_IF_ID_Rt),
        .i_branch_taken(i_branch_taken), .i_md_start(i_md_start),
        .i_halt(i_halt), .i_debug_mode(i_debug_mode), .i_step(i_step),
        .o_pc_write(o_pc_write), .o_IF_ID_write(o_IF_ID_write),
        .o_IF_ID_flush(o_IF_ID_flush), .o_ID_EX_write(o_ID_EX_write),
        .o_ID_EX_flush(o_ID_EX_flush), .o_EX_MEM_flush(o_EX_MEM_flush),
        .o_pipe_en(o_pipe_en), .o_halted(o_halted), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge i_clk);
    endtask

    task automatic clear_inputs();
        i_ID_EX_MemRead = 1'b0; i_ID_EX_Rt = '0; i_IF_ID_Rs = '0; i_IF_ID_Rt = '0;
        i_branch_taken = 1'b0; i_md_start = 1'b0; i_halt = 1'b0;
        i_debug_mode = 1'b0; i_step = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        i_reset = 1'b0;
        #1;
        check("rst_state_async", 32'(o_state), 32'd0);
        tick();
        i_reset = 1'b1;
    endtask

    initial begin
        // Reset and idle behaviour
        #1 i_reset = 1'b0;
        #1 check("reset_state", 32'(o_state), 32'd0);
        tick();
        i_reset = 1'b1;
        sample();
        check("idle_ctl", 32'(ctl), 32'(V_NORM));
        check("idle_halted", 32'(o_halted), 32'd0);
        tick();

        // Load-use beats a taken branch, then the branch flushes
        i_ID_EX_MemRead = 1'b1; i_ID_EX_Rt = 5'd5; i_IF_ID_Rs = 5'd5; i_branch_taken = 1'b1;
        sample();
        check("lu_ctl", 32'(ctl), 32'(V_LU));
        tick();
        check("lu_stay_run", 32'(o_state), 32'd0);
        i_ID_EX_MemRead = 1'b0;
        sample();
        check("br_after_lu", 32'(ctl), 32'(V_BR));
        tick();
        i_branch_taken = 1'b0; i_ID_EX_MemRead = 1'b1; i_ID_EX_Rt = 5'd0; i_IF_ID_Rs = 5'd0;
        sample();
        check("lu_r0_nostall", 32'(ctl), 32'(V_NORM));
        tick();
        i_ID_EX_Rt = 5'd7; i_IF_ID_Rs = 5'd3; i_IF_ID_Rt = 5'd7;
        sample();
        check("lu_via_rt", 32'(ctl), 32'(V_LU));
        tick();
        clear_inputs();

        // Debug freeze during MD_WAIT, then single steps count down
        i_md_start = 1'b1;
        tick();
        i_md_start = 1'b0; i_debug_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            i_halt = i[0]; i_branch_taken = ~i[0]; i_md_start = i[1];
            sample();
            check("dbg_freeze_ctl", 32'(ctl), 32'(V_OFF));
            check("dbg_freeze_st", 32'(o_state), 32'd1);
            tick();
        end
        i_halt = 1'b0; i_branch_taken = 1'b0; i_md_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_step = 1'b1;
            sample();
            check("dbg_step_ctl", 32'(ctl), 32'(V_MDW));
            tick();
            i_step = 1'b0;
            tick();
        end
        check("dbg_3steps_st", 32'(o_state), 32'd1);
        i_step = 1'b1;
        tick();
        i_step = 1'b0;
        check("dbg_4th_step_run", 32'(o_state), 32'd0);
        sample();
        check("dbg_run_nostep", 32'(ctl), 32'(V_OFF));
        tick();
        i_debug_mode = 1'b0;

        // Reset in the middle of MD_WAIT
        i_md_start = 1'b1;
        tick();
        i_md_start = 1'b0;
        tick();
        check("md_mid_st", 32'(o_state), 32'd1);
        do_reset();
        sample();
        check("post_rst_ctl", 32'(ctl), 32'(V_NORM));
        tick();
        check("post_rst_st", 32'(o_state), 32'd0);

        // MD_WAIT length with halt and branch held, then halt acts in RUN
        i_md_start = 1'b1;
        sample();
        check("md_start_ctl", 32'(ctl), 32'(V_NORM));
        tick();
        i_md_start = 1'b0; i_halt = 1'b1; i_branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("mdw_st", 32'(o_state), 32'd1);
            check("mdw_ctl", 32'(ctl), 32'(V_MDW));
            tick();
        end
        check("md_done_run", 32'(o_state), 32'd0);
        sample();
        check("halt_run_ctl", 32'(ctl), 32'(V_HALT));
        tick();
        i_halt = 1'b0; i_branch_taken = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("drain_st", 32'(o_state), 32'd2);
            check("drain_ctl", 32'(ctl), 32'(V_DRAIN));
            check("drain_halted", 32'(o_halted), 32'd0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            i_md_start = 1'b1; i_debug_mode = i[0]; i_step = i[1];
            sample();
            check("halted_st", 32'(o_state), 32'd3);
            check("halted_flag", 32'(o_halted), 32'd1);
            check("halted_ctl", 32'(ctl), 32'(V_OFF));
            tick();
        end

        // Halt + md_start + load-use together: halt wins
        do_reset();
        i_halt = 1'b1; i_md_start = 1'b1;
        i_ID_EX_MemRead = 1'b1; i_ID_EX_Rt = 5'd9; i_IF_ID_Rs = 5'd9;
        sample();
        check("simul_ctl", 32'(ctl), 32'(V_HALT));
        tick();
        check("simul_drain", 32'(o_state), 32'd2);
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_pipeline_hazard_controller.md
Name: ex_pipeline_hazard_controller

Overview:
- Sequences pipeline stall, flush and hold for the 5-stage MIPS core. Sits beside the EX forwarding unit.
- Forwarding resolves RAW hazards from EX/MEM and MEM/WB. This block covers what forwarding cannot:
  - load-use bubbles;
  - multi-cycle multiply/divide occupancy of EX;
  - taken-branch flush;
  - HALT drain;
  - debug single-step gating.
- Drives the write-enable/flush controls of PC, IF/ID, ID/EX and EX/MEM.

Parameters:
RNBITS, 5, register-number width
MD_LATENCY, 4, EX stall cycles per multiply/divide (>=1)
DRAIN_CYCLES, 4, cycles to empty pipeline after HALT decode (>=1)
CNTBITS, 3, counter width; must hold max(MD_LATENCY, DRAIN_CYCLES)-1

Ports:
i_clk  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_ID_EX_MemRead  in  1  instruction in EX is a load
i_ID_EX_Rt  in  RNBITS  load destination register in EX
i_IF_ID_Rs  in  RNBITS  rs of instruction in ID
i_IF_ID_Rt  in  RNBITS  rt of instruction in ID
i_branch_taken  in  1  branch/jump resolved taken in ID
i_md_start  in  1  mult/div entering EX this cycle
i_halt  in  1  HALT decoded in ID
i_debug_mode  in  1  1 = step mode, 0 = free run
i_step  in  1  one-cycle pulse, advances pipeline one cycle in step mode
o_pc_write  out  1  PC load enable
o_IF_ID_write  out  1  IF/ID load enable
o_IF_ID_flush  out  1  IF/ID clear to NOP
o_ID_EX_write  out  1  ID/EX load enable
o_ID_EX_flush  out  1  ID/EX clear to NOP (bubble)
o_EX_MEM_flush  out  1  EX/MEM clear to NOP
o_pipe_en  out  1  global pipeline advance enable (all stage regs, MEM/WB)
o_halted  out  1  pipeline drained after HALT
o_state  out  2  current state: 00 RUN, 01 MD_WAIT, 10 DRAIN, 11 HALTED

Behaviour:
- en = !i_debug_mode | i_step.
  - en=0: all write enables 0, all flushes 0, o_pipe_en=0.
  - State and counter frozen; all inputs ignored.
- State and counter are registered. All outputs are combinational from state, counter and inputs (Mealy).
- Reset (any time, including mid MD_WAIT/DRAIN): state=RUN, cnt=0, immediately.
  - Outputs with en=1 and no hazard: pc_write=1, IF_ID_write=1, ID_EX_write=1, o_pipe_en=1, all flushes 0, o_halted=0.
- Load-use hazard: lu = i_ID_EX_MemRead & (i_ID_EX_Rt!=0) & (i_ID_EX_Rt==i_IF_ID_Rs | i_ID_EX_Rt==i_IF_ID_Rt).
- RUN, en=1, evaluated in priority order:
  1. i_halt:
     - pc_write=0, IF_ID_flush=1.
     - Next state DRAIN, cnt=DRAIN_CYCLES-1.
  2. i_md_start:
     - Normal advance this cycle; the md op is latched into EX.
     - Next state MD_WAIT, cnt=MD_LATENCY-1.
  3. lu:
     - pc_write=0, IF_ID_write=0, ID_EX_flush=1. Stay RUN.
     - i_branch_taken is ignored this cycle; ID re-evaluates next cycle.
  4. i_branch_taken: IF_ID_flush=1, PC loads target.
  5. Otherwise normal advance.
- MD_WAIT, en=1:
  - pc_write=0, IF_ID_write=0, ID_EX_write=0, EX_MEM_flush=1.
  - If cnt==0, go to RUN; else cnt-=1.
  - Gives exactly MD_LATENCY stall cycles.
  - i_halt, i_branch_taken and lu are ignored; ID is held and re-evaluated in RUN.
- DRAIN, en=1:
  - pc_write=0, IF_ID_write=1, IF_ID_flush=1; the rest of the pipeline advances.
  - If cnt==0, go to HALTED; else cnt-=1.
- HALTED:
  - pc_write=0, IF_ID_write=0, ID_EX_write=0, o_pipe_en=0, o_halted=1.
  - Exit only by reset. i_step has no effect.
- o_pipe_en = en, except 0 in HALTED.
- Flush has priority over write on the same register.
- Counter never wraps: it saturates at 0 while transitioning.

Test Plan:
- Reset low mid MD_WAIT (cnt=2), release → o_state=00 at once, cnt=0, o_pc_write=1 on the first enabled cycle.
- Load-use: MemRead=1, Rt=5, ID Rs=5, branch_taken=1 → one cycle pc_write=0, IF_ID_write=0, ID_EX_flush=1, IF_ID_flush=0. After MemRead drops, branch then flushes IF/ID. Repeat with Rt=0 → no stall.
- md_start pulse with MD_LATENCY=4 → exactly 4 cycles of o_state=01, pc_write=0, EX_MEM_flush=1, then RUN. A halt asserted during the wait is not acted on until RUN.
- i_halt → 4 DRAIN cycles with IF_ID_flush=1, then o_halted=1 permanently. Further md_start/step produce no change.
- Debug: i_debug_mode=1, no step for 10 cycles during MD_WAIT → all enables 0, o_state and cnt unchanged. Three step pulses → cnt decrements 3.
- Simultaneous halt, md_start and lu in RUN → DRAIN chosen, md_start ignored, IF_ID_flush=1, pc_write=0.
